// File: rtl/theremin_sensor_pkg.sv
// Shared constants and event layout for the theremin edge-timestamping path.
// Channel 0 is the pitch detector, channel 1 the volume detector.
package theremin_sensor_pkg;

    localparam int NUM_CH       = 2;
    localparam int FINE_BITS    = 6;
    localparam int TS_WIDTH_DEF = 32;

    localparam int CH_PITCH  = 0;
    localparam int CH_VOLUME = 1;

    // Narrower timestamp builds keep this same {rising, ts} bit ordering.
    typedef struct packed {
        logic                    rising;
        logic [TS_WIDTH_DEF-1:0] ts;
    } edge_event_t;

    // Round-robin pick between the two channel FIFOs; only meaningful when avail != 0.
    function automatic logic rr_pick(input logic [NUM_CH-1:0] avail, input logic last_grant);
        if (avail[CH_PITCH] && avail[CH_VOLUME]) begin
            return ~last_grant;
        end
        return avail[CH_VOLUME] && !avail[CH_PITCH];
    endfunction

endpackage

// File: rtl/theremin_event_fifo.sv
// Per-channel event FIFO: power-of-two depth, accepts a push while full when a pop
// happens in the same cycle; read data is the head entry, presented combinationally.
module theremin_event_fifo
    import theremin_sensor_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(edge_event_t)
) (
    input  logic             CLK_PARALLEL,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("theremin_event_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full with a pop, wr_ptr equals rd_ptr: the head is read out before being overwritten.
    always_ff @(posedge CLK_PARALLEL) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/theremin_edge_arbiter.sv
// Timestamps pitch/volume detector edges against a free-running coarse counter and
// merges both channels round-robin onto a single registered valid/ready stream.
module theremin_edge_arbiter
    import theremin_sensor_pkg::*;
#(
    parameter int TS_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK_PARALLEL,
    input  logic                          RESET,
    input  logic [NUM_CH-1:0]             CH_ENABLE,
    input  logic [NUM_CH-1:0]             CHANGED_FLAG,
    input  logic [NUM_CH*FINE_BITS-1:0]   CHANGED_BIT,
    input  logic                          CLEAR_OVF,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic                          OUT_CHANNEL,
    output logic                          OUT_RISING,
    output logic [TS_WIDTH-1:0]           OUT_TS,
    output logic [NUM_CH-1:0]             OVERFLOW
);

    localparam int COARSE_W = TS_WIDTH - FINE_BITS;
    localparam int EVT_W    = 1 + TS_WIDTH;

    logic [COARSE_W-1:0] coarse;
    logic [NUM_CH-1:0]   level;
    logic [NUM_CH-1:0]   level_next;
    logic [NUM_CH-1:0]   push;
    logic [NUM_CH-1:0]   drop;
    logic [NUM_CH-1:0]   pop;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   empty;
    logic [NUM_CH-1:0]   avail;
    logic [EVT_W-1:0]    push_data [NUM_CH];
    logic [EVT_W-1:0]    pop_data  [NUM_CH];
    logic                last_grant;
    logic                grant;
    logic                load;

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            coarse <= '0;
        end else begin
            coarse <= coarse + 1'b1;
        end
    end

    // Level tracks the detector input even while the channel is disabled.
    assign level_next = level ^ CHANGED_FLAG;

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            level <= '0;
        end else begin
            level <= level_next;
        end
    end

    always_comb begin
        push = '0;
        drop = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            push_data[ch] = {level_next[ch], coarse, CHANGED_BIT[ch*FINE_BITS +: FINE_BITS]};
            if (CHANGED_FLAG[ch] && CH_ENABLE[ch]) begin
                if (!full[ch] || pop[ch]) begin
                    push[ch] = 1'b1;
                end else begin
                    drop[ch] = 1'b1;
                end
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_fifo
        theremin_event_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EVT_W)
        ) u_fifo (
            .CLK_PARALLEL (CLK_PARALLEL),
            .RESET        (RESET),
            .push         (push[ch]),
            .push_data    (push_data[ch]),
            .pop          (pop[ch]),
            .pop_data     (pop_data[ch]),
            .full         (full[ch]),
            .empty        (empty[ch])
        );
    end

    assign avail = ~empty;
    assign load  = !OUT_VALID || OUT_READY;
    assign grant = rr_pick(avail, last_grant);

    always_comb begin
        pop = '0;
        if (load && (|avail)) begin
            pop[grant] = 1'b1;
        end
    end

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            OUT_VALID   <= 1'b0;
            OUT_CHANNEL <= 1'b0;
            OUT_RISING  <= 1'b0;
            OUT_TS      <= '0;
            last_grant  <= 1'(CH_VOLUME);
        end else if (load) begin
            OUT_VALID <= |avail;
            if (|avail) begin
                OUT_CHANNEL            <= grant;
                {OUT_RISING, OUT_TS}   <= pop_data[grant];
                last_grant             <= grant;
            end
        end
    end

    // A drop in the same cycle as CLEAR_OVF still leaves its flag set.
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            OVERFLOW <= '0;
        end else begin
            OVERFLOW <= (CLEAR_OVF ? '0 : OVERFLOW) | drop;
        end
    end

endmodule

// File: tb/tb_theremin_edge_arbiter.sv
// Bench for theremin_edge_arbiter: a 32-bit and a 12-bit timestamp instance share stimulus
// and are compared against a queue-based event model.
`timescale 1ns/1ps
module tb_theremin_edge_arbiter;

    localparam int DEPTH = 4;

    logic        CLK_PARALLEL = 1'b0;
    logic        RESET        = 1'b1;
    logic [1:0]  CH_ENABLE    = 2'b11;
    logic [1:0]  CHANGED_FLAG = 2'b00;
    logic [11:0] CHANGED_BIT  = 12'd0;
    logic        CLEAR_OVF    = 1'b0;
    logic        OUT_READY    = 1'b1;

    logic        a_valid, a_ch, a_rise;
    logic [31:0] a_ts;
    logic [1:0]  a_ovf;
    logic        b_valid, b_ch, b_rise;
    logic [11:0] b_ts;
    logic [1:0]  b_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #2.5 CLK_PARALLEL = ~CLK_PARALLEL;

    theremin_edge_arbiter #(.TS_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut_a (
        .CLK_PARALLEL (CLK_PARALLEL), .RESET (RESET), .CH_ENABLE (CH_ENABLE),
        .CHANGED_FLAG (CHANGED_FLAG), .CHANGED_BIT (CHANGED_BIT), .CLEAR_OVF (CLEAR_OVF),
        .OUT_VALID (a_valid), .OUT_READY (OUT_READY), .OUT_CHANNEL (a_ch),
        .OUT_RISING (a_rise), .OUT_TS (a_ts), .OVERFLOW (a_ovf)
    );

    theremin_edge_arbiter #(.TS_WIDTH(12), .FIFO_DEPTH(DEPTH)) dut_b (
        .CLK_PARALLEL (CLK_PARALLEL), .RESET (RESET), .CH_ENABLE (CH_ENABLE),
        .CHANGED_FLAG (CHANGED_FLAG), .CHANGED_BIT (CHANGED_BIT), .CLEAR_OVF (CLEAR_OVF),
        .OUT_VALID (b_valid), .OUT_READY (OUT_READY), .OUT_CHANNEL (b_ch),
        .OUT_RISING (b_rise), .OUT_TS (b_ts), .OVERFLOW (b_ovf)
    );

    logic [36:0] obs_a, exp_a;
    logic [16:0] obs_b, exp_b;
    assign obs_a = {a_valid, a_ovf, a_valid ? {a_ch, a_rise, a_ts} : 34'd0};
    assign obs_b = {b_valid, b_ovf, b_valid ? {b_ch, b_rise, b_ts} : 14'd0};

    // Reference model: events as abstract records in per-channel queues.
    typedef struct {
        bit     rising;
        longint coarse;
        int     fbit;
    } mev_t;

    mev_t   mq0[$];
    mev_t   mq1[$];
    mev_t   m_slot;
    bit [1:0] m_lvl, m_ovf;
    bit     m_last, m_valid, m_ch;
    longint m_cnt;

    initial begin
        exp_a = '0;
        exp_b = '0;
        m_cnt = 0;
    end

    always @(posedge CLK_PARALLEL) begin : model
        bit [1:0]    drop;
        bit          g;
        mev_t        e;
        logic [31:0] ts32;
        logic [11:0] ts12;
        if (RESET) begin
            mq0.delete();
            mq1.delete();
            m_slot  = '{rising: 1'b0, coarse: 0, fbit: 0};
            m_lvl   = 2'b00;
            m_ovf   = 2'b00;
            m_last  = 1'b1;
            m_valid = 1'b0;
            m_ch    = 1'b0;
            m_cnt   = 0;
        end else begin
            if (!m_valid || OUT_READY) begin
                if (mq0.size() > 0 && mq1.size() > 0) g = !m_last;
                else                                  g = (mq0.size() == 0);
                if (mq0.size() > 0 || mq1.size() > 0) begin
                    if (g) m_slot = mq1.pop_front();
                    else   m_slot = mq0.pop_front();
                    m_valid = 1'b1;
                    m_ch    = g;
                    m_last  = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            drop = 2'b00;
            for (int c = 0; c < 2; c++) begin
                if (CHANGED_FLAG[c]) begin
                    m_lvl[c] = !m_lvl[c];
                    if (CH_ENABLE[c]) begin
                        e.rising = m_lvl[c];
                        e.coarse = m_cnt;
                        e.fbit   = int'(CHANGED_BIT[c*6 +: 6]);
                        if (c == 0) begin
                            if (mq0.size() < DEPTH) mq0.push_back(e);
                            else                    drop[0] = 1'b1;
                        end else begin
                            if (mq1.size() < DEPTH) mq1.push_back(e);
                            else                    drop[1] = 1'b1;
                        end
                    end
                end
            end
            if (CLEAR_OVF) m_ovf = 2'b00;
            m_ovf = m_ovf | drop;
            m_cnt++;
        end
        ts32  = 32'((m_slot.coarse % (64'd1 << 26)) * 64 + longint'(m_slot.fbit));
        ts12  = 12'((m_slot.coarse % 64) * 64 + longint'(m_slot.fbit));
        exp_a = {m_valid, m_ovf, m_valid ? {m_ch, m_slot.rising, ts32} : 34'd0};
        exp_b = {m_valid, m_ovf, m_valid ? {m_ch, m_slot.rising, ts12} : 14'd0};
    end

    task automatic tick();
        @(posedge CLK_PARALLEL);
        @(negedge CLK_PARALLEL);
    endtask

    task automatic apply_reset();
        RESET = 1'b1; CHANGED_FLAG = 2'b00; CLEAR_OVF = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        int waited = 0;
        RESET = 1'b1; CHANGED_FLAG = 2'b00; CH_ENABLE = 2'b11; OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_assert++;
            if ({a_valid, a_ch, a_rise, a_ts, a_ovf, b_valid, b_ts, b_ovf} !== '0) begin
                n_fail++;
                $display("FAIL reset_values cyc %0d got a=%h b=%h required 0", i, obs_a, obs_b);
            end
        end
        RESET = 1'b0;
        while (m_cnt != 100 && waited < 200) begin tick(); waited++; end
        CHANGED_FLAG = 2'b01; CHANGED_BIT = 12'd17;
        tick();
        CHANGED_FLAG = 2'b00;
        n_assert++;
        if (a_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_latency1 valid got %b required 0", a_valid);
        end
        tick();
        n_assert++;
        if ({a_valid, a_ch, a_rise, a_ts} !== {1'b1, 1'b0, 1'b1, 32'd6417}) begin
            n_fail++;
            $display("FAIL reset_first_event got v=%b ch=%b r=%b ts=%0d required v=1 ch=0 r=1 ts=6417",
                     a_valid, a_ch, a_rise, a_ts);
        end
        n_assert += 2;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL reset_model_a got %h required %h", obs_a, exp_a); end
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL reset_model_b got %h required %h", obs_b, exp_b); end
    endtask

    task automatic test_simultaneous();
        int chs[$];
        int cyc[$];
        apply_reset();
        OUT_READY = 1'b1; CH_ENABLE = 2'b11;
        for (int i = 0; i < 12; i++) begin
            CHANGED_FLAG = (i == 0 || i == 6) ? 2'b11 : 2'b00;
            CHANGED_BIT  = 12'($urandom);
            tick();
            n_assert += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL simul_model_a cyc %0d got %h required %h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL simul_model_b cyc %0d got %h required %h", i, obs_b, exp_b); end
            if (a_valid) begin chs.push_back(int'(a_ch)); cyc.push_back(i); end
        end
        CHANGED_FLAG = 2'b00;
        n_assert++;
        if (chs.size() != 4 || chs[0] != 0 || chs[1] != 1 || chs[2] != 0 || chs[3] != 1) begin
            n_fail++; $display("FAIL simul_order got n=%0d %p required 0,1,0,1", chs.size(), chs);
        end
        n_assert++;
        if (cyc.size() != 4 || cyc[1] != cyc[0] + 1 || cyc[3] != cyc[2] + 1) begin
            n_fail++; $display("FAIL simul_consecutive got %p required back-to-back pairs", cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] first = '0;
        int          sent  = 0;
        apply_reset();
        OUT_READY = 1'b0; CH_ENABLE = 2'b11;
        for (int i = 0; i < 9; i++) begin
            CHANGED_FLAG = (i < 6) ? 2'b01 : 2'b00;
            CHANGED_BIT  = 12'($urandom_range(0, 63));
            tick();
            n_assert += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL bp_model_a cyc %0d got %h required %h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL bp_model_b cyc %0d got %h required %h", i, obs_b, exp_b); end
            if (i == 1) first = {a_ch, a_rise, a_ts};
            if (i >= 1) begin
                n_assert++;
                if (!a_valid || {a_ch, a_rise, a_ts} !== first) begin
                    n_fail++; $display("FAIL bp_stable cyc %0d got v=%b %h required v=1 %h", i, a_valid, {a_ch, a_rise, a_ts}, first);
                end
            end
        end
        CHANGED_FLAG = 2'b00;
        n_assert++;
        if (a_ovf !== 2'b01) begin n_fail++; $display("FAIL bp_overflow got %b required 01", a_ovf); end
        CLEAR_OVF = 1'b1;
        tick();
        CLEAR_OVF = 1'b0;
        n_assert++;
        if (a_ovf !== 2'b00 || b_ovf !== 2'b00) begin
            n_fail++; $display("FAIL bp_clear got a=%b b=%b required 00", a_ovf, b_ovf);
        end
        OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (a_valid) sent++;
            tick();
            n_assert += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL bp_drain_a cyc %0d got %h required %h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL bp_drain_b cyc %0d got %h required %h", i, obs_b, exp_b); end
        end
        n_assert++;
        if (sent != 5) begin n_fail++; $display("FAIL bp_count got %0d required 5", sent); end
    endtask

    task automatic test_disabled();
        int seen = 0;
        logic rise = 1'b0;
        apply_reset();
        OUT_READY = 1'b1; CH_ENABLE = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) CH_ENABLE = 2'b11;
            CHANGED_FLAG = (i == 0 || i == 2 || i == 4) ? 2'b01 : 2'b00;
            CHANGED_BIT  = 12'($urandom);
            tick();
            n_assert += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL dis_model_a cyc %0d got %h required %h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL dis_model_b cyc %0d got %h required %h", i, obs_b, exp_b); end
            if (a_valid) begin seen++; rise = a_rise; end
        end
        n_assert++;
        if (seen != 1 || rise !== 1'b1 || a_ovf !== 2'b00) begin
            n_fail++; $display("FAIL dis_result got n=%0d rising=%b ovf=%b required n=1 rising=1 ovf=00", seen, rise, a_ovf);
        end
    endtask

    task automatic test_wrap();
        int          waited = 0;
        logic [11:0] ts[$];
        logic [11:0] diff;
        apply_reset();
        OUT_READY = 1'b1; CH_ENABLE = 2'b11;
        while ((m_cnt % 64) != 63 && waited < 200) begin tick(); waited++; end
        for (int i = 0; i < 7; i++) begin
            CHANGED_FLAG = (i < 2) ? 2'b01 : 2'b00;
            CHANGED_BIT  = (i == 0) ? 12'd60 : 12'd3;
            tick();
            n_assert += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL wrap_model_a cyc %0d got %h required %h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL wrap_model_b cyc %0d got %h required %h", i, obs_b, exp_b); end
            if (b_valid) ts.push_back(b_ts);
        end
        n_assert++;
        if (ts.size() != 2 || ts[0] !== 12'd4092 || ts[1] !== 12'd3) begin
            n_fail++; $display("FAIL wrap_ts got n=%0d %p required 4092,3", ts.size(), ts);
        end else begin
            diff = ts[1] - ts[0];
            n_assert++;
            if (diff !== 12'd7) begin n_fail++; $display("FAIL wrap_delta got %0d required 7", diff); end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        OUT_READY = 1'b0; CH_ENABLE = 2'b11;
        for (int i = 0; i < 6; i++) begin
            CHANGED_FLAG = (i < 4) ? 2'b01 : 2'b00;
            CHANGED_BIT  = 12'($urandom);
            tick();
        end
        n_assert++;
        if (a_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre valid got %b required 1", a_valid); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0; OUT_READY = 1'b1;
        n_assert++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after got a=%b b=%b required 0", a_valid, b_valid);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_assert += 2;
            if (a_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale cyc %0d valid got %b required 0", i, a_valid); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL midrst_model_b cyc %0d got %h required %h", i, obs_b, exp_b); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            RESET        = ($urandom_range(0, 199) == 0);
            CHANGED_FLAG = {($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 45)};
            CHANGED_BIT  = 12'($urandom);
            OUT_READY    = ($urandom_range(0, 99) < 60);
            CLEAR_OVF    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) CH_ENABLE = 2'($urandom);
            tick();
            n_assert += 2;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL rand_model_a cyc %0d got %h required %h", i, obs_a, exp_a); end
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL rand_model_b cyc %0d got %h required %h", i, obs_b, exp_b); end
        end
        RESET = 1'b0; CHANGED_FLAG = 2'b00; CLEAR_OVF = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge CLK_PARALLEL);
        test_reset();
        test_simultaneous();
        test_backpressure();
        test_disabled();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
